chan_rx: RTL and testbench

Clocked receiving end of a four-phase bundled-data channel, as driven by a SEND on a CHANNEL(req/ack/data) in the router. Synchronizes the incoming request, captures the data word into a small FIFO, completes the return-to-zero handshake, and presents words to synchronous logic on a valid/ready port. It is the bridge from the asynchronous arbiter/router fabric into a clocked consumer.

---
 rtl/chan_pkg.sv | 17 +
 rtl/chan_fifo.sv | 63 ++++++
 rtl/chan_rx.sv | 80 ++++++++
 tb/tb_chan_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// Shared types and helpers for the channel receiver slice.
package chan_pkg;

  // Handshake FSM states: waiting for a request, or holding the acknowledge.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACKED = 1'b1
  } state_t;

  // Bit width needed to index n things, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Circular-buffer FIFO holding words captured from the channel.
module chan_fifo
  import chan_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = clog2_min1(DEPTH),
  localparam int unsigned CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full test uses the count before this cycle's pop, so push+pop at full is refused.
  always_comb begin
    do_push = push && (count < CNT_W'(DEPTH));
    do_pop  = pop && (count != '0);
  end

  // Storage is cleared on reset so the head reads zero until the first word arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/chan_rx.sv
// Clocked receiving end of a four-phase bundled-data channel.
module chan_rx
  import chan_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_req,
  input  logic [WIDTH-1:0] ch_data,
  output logic             ch_ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = clog2_min1(DEPTH + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  state_t                 state;
  state_t                 state_nx;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [CNT_W-1:0]       count;

  // Request synchronizer; data bypasses it because it is stable while req is high.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], ch_req};
  end

  assign req_s = sync[SYNC_STAGES-1];

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: take one word per request phase, stall in IDLE while full.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_s && !full) state_nx = ST_ACKED;
      ST_ACKED: if (!req_s)         state_nx = ST_IDLE;
      default:                      state_nx = ST_IDLE;
    endcase
  end

  // Outputs: acknowledge decodes the state register; push only on the IDLE->ACKED step.
  always_comb begin
    ch_ack = (state == ST_ACKED);
    push   = (state == ST_IDLE) && req_s && !full;
  end

  // Consumer-side occupancy decode.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
  end

  chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_data(ch_data),
    .count  (count),
    .head   (out_data)
  );

endmodule

// File: tb/tb_chan_rx.sv
// Directed bench for chan_rx with WIDTH=9, DEPTH=2, SYNC_STAGES=2.
module tb_chan_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ch_req = 1'b0;
  logic [8:0] ch_data = '0;
  logic       ch_ack;
  logic       out_valid;
  logic [8:0] out_data;
  logic       out_ready = 1'b0;

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  chan_rx #(
    .WIDTH(9),
    .DEPTH(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_data  (ch_data),
    .ch_ack   (ch_ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input logic v, input int unsigned maxc);
    int unsigned n = 0;
    while (ch_ack !== v && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, ch_ack}, {31'd0, v});
  endtask

  task automatic send_full(input logic [8:0] d);
    ch_data = d;
    ch_req  = 1'b1;
    wait_ack("send_ack_hi", 1'b1, 10);
    ch_req = 1'b0;
    wait_ack("send_ack_lo", 1'b0, 10);
  endtask

  function automatic logic [8:0] word(input int unsigned i);
    return 9'((i * 37 + 5) % 512);
  endfunction

  initial begin
    int unsigned rcv;
    int unsigned cyc;
    int          cnt;
    logic        prev_ack;
    logic        pend;
    logic        rose;

    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_ack", ch_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);

    // Single SEND of 9'h155 with out_ready=1
    out_ready = 1'b1;
    ch_data = 9'h155;
    ch_req  = 1'b1;
    step(); chk("lat_rise_e1", ch_ack, 0);
    step(); chk("lat_rise_e2", ch_ack, 0);
    step(); chk("lat_rise_e3", ch_ack, 1);
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, 9'h155);
    step(); chk("one_popped", out_valid, 0);
    ch_req = 1'b0;
    step(); chk("lat_fall_e1", ch_ack, 1);
    step(); chk("lat_fall_e2", ch_ack, 1);
    step(); chk("lat_fall_e3", ch_ack, 0);
    chk("one_no_dup", out_valid, 0);

    // Back-pressure with DEPTH=2
    out_ready = 1'b0;
    send_full(9'h001);
    send_full(9'h002);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 9'h001);
    ch_data = 9'h003;
    ch_req  = 1'b1;
    repeat (5) step();
    chk("bp_held", ch_ack, 0);
    out_ready = 1'b1;
    step();
    chk("bp_no_ack_at_pop", ch_ack, 0);
    chk("bp_head2", out_data, 9'h002);
    out_ready = 1'b0;
    step();
    chk("bp_third_acked", ch_ack, 1);
    chk("bp_head2_hold", out_data, 9'h002);
    out_ready = 1'b1;
    step(); chk("bp_head3", out_data, 9'h003);
    chk("bp_valid3", out_valid, 1);
    step(); chk("bp_empty", out_valid, 0);
    out_ready = 1'b0;
    ch_req = 1'b0;
    wait_ack("bp_release", 1'b0, 10);

    // Wrap-around: 5 back-to-back SENDs consumed immediately
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      ch_data = 9'(i);
      ch_req  = 1'b1;
      wait_ack("wrap_ack_hi", 1'b1, 10);
      chk("wrap_valid", out_valid, 1);
      chk("wrap_data", out_data, i);
      ch_req = 1'b0;
      wait_ack("wrap_ack_lo", 1'b0, 10);
      chk("wrap_drained", out_valid, 0);
    end

    // Simultaneous push and pop at count=1
    out_ready = 1'b0;
    send_full(9'h0AA);
    chk("pp_head_old", out_data, 9'h0AA);
    ch_data = 9'h133;
    ch_req  = 1'b1;
    step(); step();
    out_ready = 1'b1;
    step();
    chk("pp_ack", ch_ack, 1);
    chk("pp_valid", out_valid, 1);
    chk("pp_head_new", out_data, 9'h133);
    out_ready = 1'b0;
    step();
    chk("pp_hold", out_data, 9'h133);
    out_ready = 1'b1;
    step();
    chk("pp_count1", out_valid, 0);
    out_ready = 1'b0;
    ch_req = 1'b0;
    wait_ack("pp_release", 1'b0, 10);

    // Reset mid-handshake with count=2 and ch_ack=1
    send_full(9'h011);
    ch_data = 9'h022;
    ch_req  = 1'b1;
    wait_ack("mid_ack_hi", 1'b1, 10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ack", ch_ack, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    step(); chk("mid_new_e1", ch_ack, 0);
    step(); chk("mid_new_e2", ch_ack, 0);
    step(); chk("mid_new_e3", ch_ack, 1);
    chk("mid_new_data", out_data, 9'h022);
    ch_req = 1'b0;
    wait_ack("mid_release", 1'b0, 10);
    out_ready = 1'b1;
    step();
    chk("mid_single", out_valid, 0);

    // Random out_ready over 200 SENDs with a scoreboard
    rcv = 0;
    cyc = 0;
    cnt = 0;
    prev_ack = ch_ack;
    pend = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < 200; i++) begin
          ch_data = word(i);
          ch_req  = 1'b1;
          wait_ack("rand_ack_hi", 1'b1, 400);
          ch_req = 1'b0;
          wait_ack("rand_ack_lo", 1'b0, 400);
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        while (rcv < 200 && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          rose = ch_ack && !prev_ack;
          prev_ack = ch_ack;
          cnt = cnt + int'(rose) - int'(pend);
          if (rose) chk("rand_ack_not_full", {31'd0, cnt <= 2}, 1);
          chk("rand_valid", out_valid, cnt != 0);
          out_ready = 1'($urandom_range(0, 1));
          pend = out_valid && out_ready;
          if (pend) begin
            chk("rand_data", out_data, word(rcv));
            rcv++;
          end
        end
      end
    join
    chk("rand_count", rcv, 200);
    out_ready = 1'b0;
    step();
    chk("rand_end_empty", out_valid, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
